// File: rtl/clock_enable_divider_if.sv
// Configuration port of clock_enable_divider: divisor write handshake plus
// the error pulse for writes aimed at a channel that does not exist.
interface clock_enable_divider_if #(
   parameter int unsigned WIDTH = 27
) ();
   logic             cfg_valid;
   logic             cfg_ready;
   logic [3:0]       cfg_chan;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_chan,
      output cfg_div,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_chan,
      input  cfg_div,
      output cfg_ready,
      output cfg_err
   );
endinterface

// File: rtl/clock_enable_divider.sv
// Multi-channel synchronous rate generator: per-channel tick enable and square
// wave in the clock domain, with divisors swapped glitch-free at period wrap.
module clock_enable_divider #(
   parameter int unsigned      CHANNELS    = 3,
   parameter int unsigned      WIDTH       = 27,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(32'd16777216)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  sync_clear,
   clock_enable_divider_if.slave cfg,
   output logic [CHANNELS-1:0]   tick,
   output logic [CHANNELS-1:0]   level
);
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]    cnt_r     [CHANNELS];
   logic [WIDTH-1:0]    div_r     [CHANNELS];
   logic [WIDTH-1:0]    pend_r    [CHANNELS];
   logic [CHANNELS-1:0] pf_r;
   logic [CHANNELS-1:0] tick_r;
   logic [CHANNELS-1:0] level_r;
   logic                cfg_err_r;

   logic [WIDTH-1:0]    cnt_nx_s  [CHANNELS];
   logic [WIDTH-1:0]    div_nx_s  [CHANNELS];
   logic [WIDTH-1:0]    pend_nx_s [CHANNELS];
   logic [WIDTH-1:0]    eff_s     [CHANNELS];
   logic [WIDTH-1:0]    eff_nx_s  [CHANNELS];
   logic [CHANNELS-1:0] pf_nx_s;
   logic [CHANNELS-1:0] tick_nx_s;
   logic [CHANNELS-1:0] level_nx_s;
   logic [CHANNELS-1:0] wrap_s;
   logic [CHANNELS-1:0] apply_s;
   logic [CHANNELS-1:0] sel_s;
   logic [CHANNELS-1:0] wr_s;
   logic                chan_valid_s;
   logic                cfg_ready_s;
   logic                accept_s;
   logic                cfg_err_nx_s;

   // A divisor of zero behaves like one so e-1 never underflows.
   function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
      return (d == ZERO) ? ONE : d;
   endfunction

   // Write handshake: an out-of-range channel has no selected bit, so it is always ready.
   always_comb begin
      sel_s = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         sel_s[i] = (cfg.cfg_chan == 4'(i));
      end
      chan_valid_s = |sel_s;
      cfg_ready_s  = ~|(sel_s & pf_r);
      accept_s     = cfg.cfg_valid & cfg_ready_s;
      wr_s         = accept_s ? sel_s : {CHANNELS{1'b0}};
      cfg_err_nx_s = accept_s & ~chan_valid_s;
   end

   // Per-channel next state; a new write lands after any swap so it waits for the next wrap.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         eff_s[i]     = eff_div(div_r[i]);
         wrap_s[i]    = (cnt_r[i] == (eff_s[i] - ONE));
         apply_s[i]   = pf_r[i] & (sync_clear | (en & wrap_s[i]));
         div_nx_s[i]  = apply_s[i] ? pend_r[i] : div_r[i];
         eff_nx_s[i]  = eff_div(div_nx_s[i]);
         pend_nx_s[i] = wr_s[i] ? cfg.cfg_div : pend_r[i];
         pf_nx_s[i]   = wr_s[i] | (pf_r[i] & ~apply_s[i]);
         if (sync_clear) begin
            cnt_nx_s[i]   = ZERO;
            tick_nx_s[i]  = 1'b0;
            level_nx_s[i] = (eff_nx_s[i] == ONE);
         end else if (en) begin
            if (wrap_s[i]) begin
               cnt_nx_s[i]  = ZERO;
               tick_nx_s[i] = 1'b1;
            end else begin
               cnt_nx_s[i]  = cnt_r[i] + ONE;
               tick_nx_s[i] = 1'b0;
            end
            level_nx_s[i] = (cnt_nx_s[i] >= (eff_nx_s[i] >> 1));
         end else begin
            cnt_nx_s[i]   = cnt_r[i];
            tick_nx_s[i]  = 1'b0;
            level_nx_s[i] = level_r[i];
         end
      end
   end

   // State registers; reset discards counts and any pending divisor.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_r[i]  <= ZERO;
            div_r[i]  <= DEFAULT_DIV << i;
            pend_r[i] <= ZERO;
         end
         pf_r      <= {CHANNELS{1'b0}};
         tick_r    <= {CHANNELS{1'b0}};
         level_r   <= {CHANNELS{1'b0}};
         cfg_err_r <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_r[i]  <= cnt_nx_s[i];
            div_r[i]  <= div_nx_s[i];
            pend_r[i] <= pend_nx_s[i];
         end
         pf_r      <= pf_nx_s;
         tick_r    <= tick_nx_s;
         level_r   <= level_nx_s;
         cfg_err_r <= cfg_err_nx_s;
      end
   end

   assign tick          = tick_r;
   assign level         = level_r;
   assign cfg.cfg_ready = cfg_ready_s;
   assign cfg.cfg_err   = cfg_err_r;
endmodule

// File: tb/tb_clock_enable_divider.sv
// Directed bench for clock_enable_divider with WIDTH=8, DEFAULT_DIV=4, three channels.
module tb_clock_enable_divider;
   localparam int unsigned CHANNELS = 3;
   localparam int unsigned WIDTH    = 8;

   // Bit j is the expectation after edge 37+j while ch1 swaps from 8 to 5.
   localparam logic [13:0] CH1_TICK_EXP  = 14'b10000100001000;
   localparam logic [13:0] CH1_LEVEL_EXP = 14'b01110011100111;

   logic                clock = 1'b0;
   logic                reset;
   logic                en;
   logic                sync_clear;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] level;
   int                  n_checks = 0;
   int                  n_fail   = 0;

   clock_enable_divider_if #(.WIDTH(WIDTH)) cfg_if ();

   clock_enable_divider #(
      .CHANNELS    (CHANNELS),
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (8'd4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .sync_clear (sync_clear),
      .cfg        (cfg_if),
      .tick       (tick),
      .level      (level)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expected);
      n_checks++;
      if (obs !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg_write(input logic [3:0] chan, input logic [7:0] div);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_chan  = chan;
      cfg_if.cfg_div   = div;
      step();
      cfg_if.cfg_valid = 1'b0;
   endtask

   // Default divisors 4/8/16 counted from reset release: tick when k%p==0, level high for the upper half.
   task automatic run_defaults(input int n, input string tag);
      logic [2:0] t_exp;
      logic [2:0] l_exp;
      int         p;
      for (int k = 1; k <= n; k++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            p        = 4 << i;
            t_exp[i] = ((k % p) == 0);
            l_exp[i] = ((k % p) >= (p / 2));
         end
         check_eq($sformatf("%s_k%0d", tag, k), 32'({tick, level}), 32'({t_exp, l_exp}));
      end
   endtask

   initial begin
      reset            = 1'b1;
      en               = 1'b1;
      sync_clear       = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_chan  = 4'd0;
      cfg_if.cfg_div   = 8'd0;
      repeat (3) step();
      check_eq("rst_tick",  32'(tick), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_err",   32'(cfg_if.cfg_err), 32'd0);
      check_eq("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
      reset = 1'b0;

      run_defaults(32, "dflt");

      repeat (3) step();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_chan  = 4'd1;
      cfg_if.cfg_div   = 8'd5;
      #1;
      check_eq("wr_ready", 32'(cfg_if.cfg_ready), 32'd1);
      step();
      cfg_if.cfg_div = 8'd7;
      #1;
      check_eq("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
      for (int j = 0; j < 14; j++) begin
         step();
         if (j == 0) begin
            cfg_if.cfg_valid = 1'b0;
         end
         check_eq($sformatf("swap_tick_j%0d", j), 32'(tick[1]), 32'(CH1_TICK_EXP[j]));
         check_eq($sformatf("swap_level_j%0d", j), 32'(level[1]), 32'(CH1_LEVEL_EXP[j]));
         if (j == 2) begin
            check_eq("stall_ready", 32'(cfg_if.cfg_ready), 32'd0);
         end
         if (j == 3) begin
            check_eq("swap_ready", 32'(cfg_if.cfg_ready), 32'd1);
         end
      end

      en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         check_eq($sformatf("gap_j%0d", j), 32'({tick, level[0]}), 32'b0001);
      end
      en = 1'b1;
      step();
      check_eq("gap_late0", 32'(tick[0]), 32'd0);
      step();
      check_eq("gap_late1", 32'(tick[0]), 32'd1);

      cfg_write(4'd0, 8'd6);
      repeat (3) step();
      check_eq("ch0_swap_tick", 32'(tick[0]), 32'd1);
      cfg_write(4'd1, 8'd6);
      #1;
      check_eq("ch1_pend", 32'(cfg_if.cfg_ready), 32'd0);
      sync_clear = 1'b1;
      step();
      sync_clear = 1'b0;
      check_eq("sc_tick",  32'(tick), 32'd0);
      check_eq("sc_level", 32'(level), 32'd0);
      check_eq("sc_ready", 32'(cfg_if.cfg_ready), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         step();
         check_eq($sformatf("sc_k%0d", k), 32'({tick[1:0], level[1:0]}),
                  32'({(k == 6) ? 2'b11 : 2'b00, (k >= 3 && k <= 5) ? 2'b11 : 2'b00}));
      end

      cfg_write(4'd0, 8'd0);
      cfg_write(4'd1, 8'd1);
      repeat (4) step();
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq($sformatf("e1_k%0d", k), 32'({tick[1:0], level[1:0]}), 32'b1111);
      end

      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_chan  = 4'd7;
      cfg_if.cfg_div   = 8'd3;
      #1;
      check_eq("bad_ready", 32'(cfg_if.cfg_ready), 32'd1);
      step();
      cfg_if.cfg_valid = 1'b0;
      check_eq("bad_err_hi", 32'(cfg_if.cfg_err), 32'd1);
      step();
      check_eq("bad_err_lo", 32'(cfg_if.cfg_err), 32'd0);
      step();
      check_eq("bad_nochg", 32'({tick[1:0], level[1:0]}), 32'b1111);

      cfg_write(4'd2, 8'd3);
      #1;
      check_eq("rst_pend", 32'(cfg_if.cfg_ready), 32'd0);
      reset = 1'b1;
      step();
      check_eq("mid_rst_tick",  32'(tick), 32'd0);
      check_eq("mid_rst_level", 32'(level), 32'd0);
      check_eq("mid_rst_err",   32'(cfg_if.cfg_err), 32'd0);
      check_eq("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
      reset = 1'b0;
      run_defaults(20, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
